// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM-like port arbiter: master IDs, request bus layout, lock states.
package sram_arbiter_pkg;

  localparam logic MASTER_INST = 1'b0;
  localparam logic MASTER_DATA = 1'b1;

  // wr + size + wstrb + addr + wdata
  localparam int SRAM_REQ_WD = 71;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HOLD = 1'b1
  } lock_state_e;

endpackage

// File: rtl/sram_arbiter_id_fifo.sv
// In-order master-ID FIFO; push and pop may happen in the same cycle, also when full.
module arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  // Head is read combinationally so a response is routed in the cycle it arrives.
  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM-like port between the IF and MEM masters; responses are routed in issue order.
// Build option ARB_ROUND_ROBIN_EN: round-robin unlocked selection instead of data-over-inst priority.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int ID_W        = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_busy
);

  lock_state_e state_reg, state_next;
  logic        lock_id_reg, lock_id_next;
  logic        pick, sel, sel_req;
  logic        fifo_full, fifo_empty, pop, accept;
  logic [ID_W-1:0]        head_id;
  logic [SRAM_REQ_WD-1:0] inst_bus, data_bus;
  sram_req_t              mem_bus;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_reg;

  always_ff @(posedge clk) begin
    if (reset)       rr_reg <= MASTER_INST;
    else if (accept) rr_reg <= ~sel;
  end

  assign pick = (inst_req && data_req) ? rr_reg : (data_req ? MASTER_DATA : MASTER_INST);
`else
  assign pick = data_req ? MASTER_DATA : MASTER_INST;
`endif

  assign sel     = (state_reg == LOCK_HOLD) ? lock_id_reg : pick;
  assign sel_req = (sel == MASTER_DATA) ? data_req : inst_req;
  assign pop     = mem_data_ok && !fifo_empty;
  // A pop in the same cycle frees the slot the new request needs.
  assign mem_req = sel_req && !(fifo_full && !pop);
  assign accept  = mem_req && mem_addr_ok;

  assign inst_bus = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign data_bus = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
  assign mem_bus  = sram_req_t'((sel == MASTER_DATA) ? data_bus : inst_bus);
  assign mem_wr    = mem_bus.wr;
  assign mem_size  = mem_bus.size;
  assign mem_wstrb = mem_bus.wstrb;
  assign mem_addr  = mem_bus.addr;
  assign mem_wdata = mem_bus.wdata;

  assign inst_addr_ok = accept && (sel == MASTER_INST);
  assign data_addr_ok = accept && (sel == MASTER_DATA);
  assign inst_data_ok = pop && (head_id[0] == MASTER_INST);
  assign data_data_ok = pop && (head_id[0] == MASTER_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;
  assign arb_busy     = !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= LOCK_IDLE;
      lock_id_reg <= MASTER_INST;
    end else begin
      state_reg   <= state_next;
      lock_id_reg <= lock_id_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    lock_id_next = lock_id_reg;
    case (state_reg)
      LOCK_IDLE: begin
        if (mem_req && !mem_addr_ok) begin
          state_next   = LOCK_HOLD;
          lock_id_next = sel;
        end
      end
      LOCK_HOLD: begin
        if (accept || !sel_req) state_next = LOCK_IDLE;
      end
      default: state_next = LOCK_IDLE;
    endcase
  end

  arb_id_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (ID_W'(sel)),
    .pop       (pop),
    .head      (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifndef SYNTHESIS
  // Responses of transactions discarded by reset may still trickle in until the next acceptance.
  logic stale_ok_reg;

  always_ff @(posedge clk) begin
    if (reset)       stale_ok_reg <= 1'b1;
    else if (accept) stale_ok_reg <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mem_data_ok && fifo_empty && !stale_ok_reg))
        else $error("sram_arbiter: mem_data_ok with no outstanding transaction");
      assert (!(state_reg == LOCK_HOLD && !sel_req))
        else $error("sram_arbiter: held master dropped its request before addr_ok");
    end
  end
`endif

endmodule
